// File: rtl/write_back_stage_if.sv
// Bundles the MEM-stage result fields and the register-file write port of the write-back stage.
// No latency of its own; it carries wires only.
// No backpressure channel: the stall and flush controls travel with the MEM-side fields.
interface write_back_stage_if #(
    parameter int B = 32,
    parameter int D = 5,
    parameter int C = 32
);
    logic         stall;
    logic         flush;
    logic         in_valid;
    logic [B-1:0] mem_data;
    logic [B-1:0] ALU_data;
    logic [B-1:0] pc_plus4;
    logic [1:0]   wb_sel;
    logic [1:0]   load_size;
    logic         load_unsigned;
    logic [1:0]   byte_off;
    logic         RegWrite;
    logic [D-1:0] write_reg;
    logic         reg_we;
    logic [D-1:0] reg_addr;
    logic [B-1:0] data_out;
    logic [C-1:0] retired;

    // MEM-stage side: drives results and controls, observes the write port
    modport master (
        output stall, flush, in_valid, mem_data, ALU_data, pc_plus4,
               wb_sel, load_size, load_unsigned, byte_off, RegWrite, write_reg,
        input  reg_we, reg_addr, data_out, retired
    );

    // Write-back stage side
    modport slave (
        input  stall, flush, in_valid, mem_data, ALU_data, pc_plus4,
               wb_sel, load_size, load_unsigned, byte_off, RegWrite, write_reg,
        output reg_we, reg_addr, data_out, retired
    );
endinterface

// File: rtl/write_back_stage.sv
// MEM/WB pipeline register: selects the ALU, aligned load or link value and drives the register-file write port.
// Latency is 1 cycle, from the capture edge to the outputs.
// Stall holds every register and flush clears the valid bit; there is no other backpressure.
module write_back_stage #(
    parameter int B = 32,
    parameter int D = 5,
    parameter int C = 32
) (
    input  logic              clk,
    input  logic              reset,
    write_back_stage_if.slave bus
);
    localparam logic [1:0] SEL_MEM   = 2'b01;
    localparam logic [1:0] SEL_PC4   = 2'b10;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    logic         valid_q,    valid_d;
    logic         regwrite_q, regwrite_d;
    logic [D-1:0] addr_q,     addr_d;
    logic [B-1:0] data_q,     data_d;
    logic [C-1:0] retired_q,  retired_d;

    logic [7:0]   ld_byte;
    logic [15:0]  ld_half;
    logic [B-1:0] load_val;
    logic [B-1:0] sel_val;

    // Pick the addressed byte/half out of the loaded word; half loads ignore byte_off[0]
    always_comb begin
        ld_byte = bus.mem_data[{bus.byte_off, 3'b000} +: 8];
        ld_half = bus.mem_data[{bus.byte_off[1], 4'b0000} +: 16];
    end

    // Sign- or zero-extend sub-word loads; word loads pass the raw word through
    always_comb begin
        load_val = bus.mem_data;
        case (bus.load_size)
            SIZE_BYTE: load_val = {{(B-8){~bus.load_unsigned & ld_byte[7]}}, ld_byte};
            SIZE_HALF: load_val = {{(B-16){~bus.load_unsigned & ld_half[15]}}, ld_half};
            default:   load_val = bus.mem_data;
        endcase
    end

    // Write-back source select is pre-computed so data_out comes straight from a flop
    always_comb begin
        case (bus.wb_sel)
            SEL_MEM: sel_val = load_val;
            SEL_PC4: sel_val = bus.pc_plus4;
            default: sel_val = bus.ALU_data;
        endcase
    end

    // Capture priority: flush kills the valid bit, stall holds everything, otherwise load
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        addr_d     = addr_q;
        data_d     = data_q;
        retired_d  = retired_q;
        if (bus.flush) begin
            valid_d    = 1'b0;
            regwrite_d = bus.RegWrite;
            addr_d     = bus.write_reg;
            data_d     = sel_val;
        end else if (!bus.stall) begin
            valid_d    = bus.in_valid;
            regwrite_d = bus.RegWrite;
            addr_d     = bus.write_reg;
            data_d     = sel_val;
            if (bus.in_valid) begin
                retired_d = retired_q + C'(1);
            end
        end
    end

    // Stage registers, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            retired_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            retired_q  <= retired_d;
        end
    end

    // Writes to $zero never reach the register file
    assign bus.reg_we   = valid_q & regwrite_q & (addr_q != '0);
    assign bus.reg_addr = addr_q;
    assign bus.data_out = data_q;
    assign bus.retired  = retired_q;
endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;
    int   exp_ret;

    write_back_stage_if #(.B(32), .D(5), .C(32)) wb ();
    write_back_stage_if #(.B(32), .D(5), .C(4))  wb4 ();

    write_back_stage #(.B(32), .D(5), .C(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (wb)
    );

    write_back_stage #(.B(32), .D(5), .C(4)) dut_c4 (
        .clk   (clk),
        .reset (reset),
        .bus   (wb4)
    );

    // The narrow-counter instance sees the same stimulus
    assign wb4.stall         = wb.stall;
    assign wb4.flush         = wb.flush;
    assign wb4.in_valid      = wb.in_valid;
    assign wb4.mem_data      = wb.mem_data;
    assign wb4.ALU_data      = wb.ALU_data;
    assign wb4.pc_plus4      = wb.pc_plus4;
    assign wb4.wb_sel        = wb.wb_sel;
    assign wb4.load_size     = wb.load_size;
    assign wb4.load_unsigned = wb.load_unsigned;
    assign wb4.byte_off      = wb.byte_off;
    assign wb4.RegWrite      = wb.RegWrite;
    assign wb4.write_reg     = wb.write_reg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One capture edge, then settle past it before anything is sampled or driven
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] addr, input logic [31:0] data);
        chk({tag, ".we"},   {31'd0, wb.reg_we}, {31'd0, we});
        chk({tag, ".addr"}, {27'd0, wb.reg_addr}, {27'd0, addr});
        chk({tag, ".data"}, wb.data_out, data);
    endtask

    typedef struct {
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t ld_tab[7];
    logic [1:0]  sel_tab[4];
    logic [31:0] sel_exp[4];

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        exp_ret = 0;

        wb.stall = 0; wb.flush = 0; wb.in_valid = 0;
        wb.mem_data = 32'h0; wb.ALU_data = 32'h0; wb.pc_plus4 = 32'h0;
        wb.wb_sel = 2'b00; wb.load_size = 2'b00; wb.load_unsigned = 0;
        wb.byte_off = 2'b00; wb.RegWrite = 0; wb.write_reg = 5'd0;

        // Reset state
        reset = 1'b1;
        step();
        step();
        check_out("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.retired", wb.retired, 32'd0);
        reset = 1'b0;

        // Source select on consecutive edges; 11 falls back to ALU
        sel_tab = '{2'b00, 2'b01, 2'b10, 2'b11};
        sel_exp = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h0040_0010, 32'h0000_1234};
        wb.in_valid = 1; wb.RegWrite = 1; wb.write_reg = 5'd8;
        wb.ALU_data = 32'h0000_1234; wb.mem_data = 32'hDEAD_BEEF; wb.pc_plus4 = 32'h0040_0010;
        for (int i = 0; i < 4; i++) begin
            wb.wb_sel = sel_tab[i];
            step();
            exp_ret++;
            check_out($sformatf("sel%0d", i), 1'b1, 5'd8, sel_exp[i]);
        end
        chk("sel.retired", wb.retired, 32'd4);

        // Sub-word load alignment and extension
        ld_tab[0] = '{2'b10, 1'b0, 2'd0, 32'h0000_0001};
        ld_tab[1] = '{2'b10, 1'b0, 2'd3, 32'hFFFF_FF80};
        ld_tab[2] = '{2'b10, 1'b1, 2'd2, 32'h0000_00FF};
        ld_tab[3] = '{2'b01, 1'b0, 2'd2, 32'hFFFF_80FF};
        ld_tab[4] = '{2'b01, 1'b1, 2'd0, 32'h0000_7F01};
        ld_tab[5] = '{2'b01, 1'b0, 2'd3, 32'hFFFF_80FF};
        ld_tab[6] = '{2'b00, 1'b0, 2'd3, 32'h80FF_7F01};
        wb.mem_data = 32'h80FF_7F01; wb.wb_sel = 2'b01; wb.write_reg = 5'd3;
        for (int i = 0; i < 7; i++) begin
            wb.load_size = ld_tab[i].size;
            wb.load_unsigned = ld_tab[i].uns;
            wb.byte_off = ld_tab[i].off;
            step();
            exp_ret++;
            chk($sformatf("load%0d.data", i), wb.data_out, ld_tab[i].exp);
        end
        chk("load.retired", wb.retired, 32'(exp_ret));

        // Writes to $zero are suppressed but still retire
        wb.wb_sel = 2'b00; wb.load_size = 2'b00; wb.byte_off = 2'd0;
        wb.write_reg = 5'd0; wb.ALU_data = 32'h0000_5555;
        step();
        exp_ret++;
        check_out("zero", 1'b0, 5'd0, 32'h0000_5555);
        chk("zero.retired", wb.retired, 32'(exp_ret));

        // Capture A, then stall three cycles with the inputs disturbed
        wb.write_reg = 5'd9; wb.ALU_data = 32'hA5A5_0001;
        step();
        exp_ret++;
        check_out("capA", 1'b1, 5'd9, 32'hA5A5_0001);
        wb.stall = 1; wb.write_reg = 5'd10; wb.ALU_data = 32'h1111_2222; wb.RegWrite = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("stall%0d", i), 1'b1, 5'd9, 32'hA5A5_0001);
            chk($sformatf("stall%0d.retired", i), wb.retired, 32'(exp_ret));
        end
        wb.RegWrite = 1;
        wb.flush = 1;
        step();
        chk("flush.we", {31'd0, wb.reg_we}, 32'd0);
        chk("flush.retired", wb.retired, 32'(exp_ret));
        wb.flush = 0; wb.stall = 0;

        // Asynchronous reset in the middle of a cycle
        wb.write_reg = 5'd12; wb.ALU_data = 32'h0BAD_F00D;
        step();
        exp_ret++;
        check_out("pre_rst", 1'b1, 5'd12, 32'h0BAD_F00D);
        #2;
        reset = 1'b1;
        #1;
        check_out("mid_rst", 1'b0, 5'd0, 32'h0);
        chk("mid_rst.retired", wb.retired, 32'd0);
        chk("mid_rst.retired4", {28'd0, wb4.retired}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Narrow counter wraps 15 -> 0
        wb.RegWrite = 0;
        for (int i = 0; i < 15; i++) step();
        chk("wrap.pre", {28'd0, wb4.retired}, 32'd15);
        step();
        chk("wrap.post", {28'd0, wb4.retired}, 32'd0);
        chk("wrap.wide", wb.retired, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Parametrised MEM/WB pipeline register plus write-back select for the MIPS pipeline.
- Latches MEM-stage results and selects the write-back source: ALU, load data, or PC+4 for link instructions.
- Aligns and extends sub-word loads.
- Drives the register-file write port and the forwarding bus.
- Counts retired instructions.
- Sits between the memory-access stage and the register file.

Parameters:
- B, 32, datapath width in bits (must be 32 for sub-word load handling).
- D, 5, register address width.
- C, 32, retire counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold the pipeline register contents.
- flush  in  1  invalidate the instruction being captured.
- in_valid  in  1  MEM stage holds a real instruction.
- mem_data  in  B  raw word read from data memory.
- ALU_data  in  B  ALU result.
- pc_plus4  in  B  link address.
- wb_sel  in  2  source select: 00 = ALU, 01 = MEM, 10 = PC+4, 11 = ALU.
- load_size  in  2  00 = word, 01 = half, 10 = byte, 11 = word.
- load_unsigned  in  1  zero-extend (1) or sign-extend (0) sub-word loads.
- byte_off  in  2  address bits [1:0] of the load.
- RegWrite  in  1  instruction writes the register file.
- write_reg  in  D  destination register.
- reg_we  out  1  register-file write enable.
- reg_addr  out  D  register-file write address.
- data_out  out  B  write-back data; also the forwarding value.
- retired  out  C  count of valid instructions that passed write-back.

Behaviour:
- Reset (asynchronous, active-high): all stage registers clear.
  - reg_we = 0, reg_addr = 0, data_out = 0, retired = 0.
  - Reset takes effect immediately, mid-operation included.
  - First capture happens on the first rising clk after reset deasserts.
- Latency: 1 cycle. Inputs are sampled on the rising edge; the outputs reflect them in the following cycle.
- Capture priority on each edge: flush > stall > normal.
  - flush = 1: the stage valid bit is cleared, so reg_we = 0 next cycle. Data and address registers may load but are don't-care. retired does not increment. flush overrides a simultaneous stall.
  - stall = 1 (flush = 0): all registers hold, including reg_we. retired does not increment.
  - Normal: capture all fields. valid_q = in_valid.
- reg_we = valid_q AND RegWrite_q AND (reg_addr != 0). Writes to $zero are always suppressed.
- Source selection is done on the registered fields (combinational after the flop, or pre-computed before it). In both cases data_out must equal the function below applied to the values captured at the last edge.
- MEM path alignment: shifted = mem_data >> (8 * byte_off) for byte loads, and >> (16 * byte_off[1]) for half loads.
  - byte: lower 8 bits of shifted, extended to B bits.
  - half: lower 16 bits of shifted, extended to B bits. byte_off[0] is ignored for half loads.
  - Extension is zero-extension if load_unsigned = 1, otherwise sign-extension.
  - word: mem_data unchanged; byte_off is ignored.
- wb_sel = 11 behaves as 00 (ALU).
- retired increments by 1 on every non-stalled, non-flushed edge where the captured in_valid = 1, regardless of RegWrite (stores and branches count). It wraps from all-ones to 0 with no flag.
- data_out is valid whenever reg_we = 1. Otherwise it still presents the selected value of the captured fields.
- No handshake beyond stall/flush. The upstream stage must hold its inputs stable while stall = 1.

Test Plan:
- Reset mid-stream: assert reset asynchronously between edges -> reg_we, reg_addr, data_out and retired read 0 before the next edge.
- Source select: in_valid = 1, RegWrite = 1, write_reg = 8, ALU_data = 0x0000_1234, mem_data = 0xDEAD_BEEF, pc_plus4 = 0x0040_0010. Apply wb_sel = 00, 01, 10, 11 on consecutive edges -> data_out = 0x1234, 0xDEADBEEF, 0x00400010, 0x1234, each with reg_we = 1 and reg_addr = 8. retired advances by 4.
- Sub-word loads, mem_data = 0x80FF_7F01, wb_sel = 01:
  - byte, signed, off 0 -> 0x0000_0001.
  - byte, signed, off 3 -> 0xFFFF_FF80.
  - byte, unsigned, off 2 -> 0x0000_00FF.
  - half, signed, off 2 -> 0xFFFF_80FF.
  - half, unsigned, off 0 -> 0x0000_7F01.
- $zero suppression: RegWrite = 1, write_reg = 0 -> reg_we = 0, but retired still increments.
- Stall then flush: capture instruction A, then stall for 3 cycles -> outputs hold A and retired is unchanged. Then assert flush together with stall -> reg_we = 0 next cycle and retired is unchanged.
- Counter wrap: C = 4, preload by issuing 15 valid instructions, then one more -> retired goes 15 -> 0.
